simplez_ctrl: RTL and testbench
===============================

# simplez_ctrl

Complete control unit for the Simplez CPU. It sequences the existing datapath (CP, RA, RI, AC, main memory) through fetch, decode and operand phases for all eight opcodes. It replaces the provisional sequencer in the top level. It also adds memory wait handling, run/idle control and a debug state output.

## Interface
Parameters:
- none; opcode, state and ALU-operation encodings come from the shared package.

Ports:
- clk  in  1  system clock; all state updates on the falling edge.
- rstn  in  1  reset, synchronous, active-low.
- co  in  3  opcode, RI[11:9].
- ac_zero  in  1  AC == 0, from the datapath.
- mem_rdy  in  1  memory ready; low extends the current memory phase.
- run  in  1  level; low parks the CPU at the next instruction boundary.
- lec, esc  out  1 each  memory read / write.
- era, eri, eac  out  1 each  load RA / RI / AC.
- sri, scp, sac  out  1 each  drive busAi from CD / busAi from CP / busD from AC.
- incp, ecp, ccp  out  1 each  CP increment / load from busAi / clear.
- alu_op  out  2  00 pass busD, 01 AC+busD, 10 AC−1, 11 zero.
- stop  out  1  high while halted.
- boundary  out  1  one-cycle pulse in the last cycle of each instruction.
- state_dbg  out  3  current state encoding.

## Operation
States: INI, I0, I1, O0, O1, HLT, IDLE.

Decoding:
- Moore outputs per state, plus `co` / `ac_zero` decode in I1, O0 and O1.
- Microorders not listed below are 0 in that state.

INI (one cycle after reset release):
- ccp = 1.
- Next state I0. RA is already 0 from datapath reset.

I0 (fetch):
- lec = 1, eri = 1, incp = 1.
- If mem_rdy = 0: stay in I0 with only lec = 1 (eri and incp suppressed).

I1 (decode / execute), by opcode:
- ST, LD, ADD: sri, era; next O0.
- BR: sri, ecp, era; next END.
- BZ with ac_zero = 1: same as BR.
- BZ with ac_zero = 0: scp, era; next END.
- CLR: eac with alu_op 11, plus scp, era; next END.
- DEC: eac with alu_op 10, plus scp, era; next END.
- HALT: no microorders; next HLT.

O0 (operand access):
- ST: sac, esc.
- LD, ADD: lec.
- If mem_rdy = 0: stay in O0 with the same lec/esc/sac, and eac suppressed.
- LD: eac with alu_op 00, asserted on the completing cycle.
- ADD: eac with alu_op 01, asserted on the completing cycle.
- Next O1.

O1 (restore):
- scp, era (RA ← CP); next END.

END (resolved at the edge leaving I1 or O1):
- If run = 1: go to I0.
- Otherwise: go to IDLE.
- `boundary` is high in that last cycle.

IDLE:
- No microorders.
- RA already holds CP.
- Go to I0 on the first cycle with run = 1.

HLT:
- stop = 1, no microorders.
- Exits only through reset; run is ignored.

## Timing
- Memory samples on the rising edge mid-state. Read data is valid on busD before the closing falling edge.
- Latency with mem_rdy held high:
  - ST, LD, ADD: 4 cycles.
  - BR, BZ, CLR, DEC: 2 cycles.
  - HALT: 2 cycles to reach HLT.
- Each mem_rdy = 0 cycle adds exactly one cycle. A wait state never repeats incp or eac.
- rstn = 0 on any edge, including mid-instruction:
  - state ← INI.
  - All outputs forced 0 combinationally while rstn = 0, including stop, boundary and ccp.
  - state_dbg reads INI.
- run falling mid-instruction: the instruction completes, then the CPU parks in IDLE.
- run toggling while in HLT: no effect.
- Unknown state encoding: recover to I0 on the next edge.

## Configuration
Macro SIMPLEZ_STEP_EN.

When defined:
- Adds input `step` (1 bit).
- A step = 1 cycle in IDLE starts exactly one instruction. At END the CPU returns to IDLE unless run = 1.
- step outside IDLE is ignored.
- A step held high for N cycles counts as one request; it must return low before the next request.

When undefined:
- There is no step port.
- IDLE exits only on run.

## Structure
- Package simplez_pkg holds:
  - opcode localparams ST = 0 … HALT = 7;
  - state encodings INI = 0, I0 = 1, I1 = 2, O0 = 3, O1 = 4, HLT = 5, IDLE = 6;
  - alu_op codes.
- Sub-module simplez_udecode: purely combinational decode (state, co, ac_zero, mem_rdy → microorders).
- simplez_ctrl itself keeps the state register, the END/run/step logic and the reset gating.

## Test plan
- Reset, then run = 1, mem_rdy = 1, co = LD (1):
  - INI asserts ccp.
  - I0 asserts lec/eri/incp.
  - I1 asserts sri/era.
  - O0 asserts lec and eac with alu_op 00.
  - O1 asserts scp/era; boundary pulses in O1.
- co = BZ (4):
  - ac_zero = 1: I1 asserts sri/ecp/era, 2-cycle instruction.
  - ac_zero = 0: I1 asserts scp/era only; ecp stays 0.
- co = ADD (2) with mem_rdy low for 3 cycles in O0: O0 lasts 4 cycles, and eac with alu_op 01 is asserted exactly once.
- co = HALT (7): HLT is reached with stop = 1. Toggling run leaves stop = 1. Asserting rstn = 0 clears stop in the same cycle.
- run dropped during O0 of ST (0): the instruction completes, esc is asserted once, state_dbg = 6 (IDLE) afterwards, and no lec is asserted while idle.
- With SIMPLEZ_STEP_EN and run = 0: a 5-cycle step pulse executes one CLR (5), with alu_op 11 asserted once, then returns to IDLE.

Source files
------------

// File: rtl/simplez_pkg.sv
// Simplez shared encodings: opcodes, controller states, ALU operations
// and the microorder bundle passed from the decoder to the controller.
package simplez_pkg;

    localparam logic [2:0] ST   = 3'd0;
    localparam logic [2:0] LD   = 3'd1;
    localparam logic [2:0] ADD  = 3'd2;
    localparam logic [2:0] BR   = 3'd3;
    localparam logic [2:0] BZ   = 3'd4;
    localparam logic [2:0] CLR  = 3'd5;
    localparam logic [2:0] DEC  = 3'd6;
    localparam logic [2:0] HALT = 3'd7;

    typedef enum logic [2:0] {
        INI  = 3'd0,
        I0   = 3'd1,
        I1   = 3'd2,
        O0   = 3'd3,
        O1   = 3'd4,
        HLT  = 3'd5,
        IDLE = 3'd6
    } state_e;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_DEC  = 2'b10;
    localparam logic [1:0] ALU_ZERO = 2'b11;

    typedef struct packed {
        logic       lec;
        logic       esc;
        logic       era;
        logic       eri;
        logic       eac;
        logic       sri;
        logic       scp;
        logic       sac;
        logic       incp;
        logic       ecp;
        logic       ccp;
        logic [1:0] alu_op;
    } uorders_t;

    localparam uorders_t UO_NONE = '0;

endpackage

// File: rtl/simplez_udecode.sv
// Simplez microorder decoder: purely combinational map from
// (state, opcode, ac_zero, mem_rdy) to the datapath microorders.
module simplez_udecode
    import simplez_pkg::*;
(
    input  state_e      state,
    input  logic [2:0]  co,
    input  logic        ac_zero,
    input  logic        mem_rdy,
    output uorders_t    uo
);

    always_comb begin
        uo = UO_NONE;
        case (state)
            INI: uo.ccp = 1'b1;
            I0: begin
                uo.lec  = 1'b1;
                uo.eri  = mem_rdy;
                uo.incp = mem_rdy;
            end
            I1: begin
                case (co)
                    ST, LD, ADD: begin
                        uo.sri = 1'b1;
                        uo.era = 1'b1;
                    end
                    BR: begin
                        uo.sri = 1'b1;
                        uo.ecp = 1'b1;
                        uo.era = 1'b1;
                    end
                    BZ: begin
                        uo.sri = ac_zero;
                        uo.ecp = ac_zero;
                        uo.scp = ~ac_zero;
                        uo.era = 1'b1;
                    end
                    CLR: begin
                        uo.eac    = 1'b1;
                        uo.alu_op = ALU_ZERO;
                        uo.scp    = 1'b1;
                        uo.era    = 1'b1;
                    end
                    DEC: begin
                        uo.eac    = 1'b1;
                        uo.alu_op = ALU_DEC;
                        uo.scp    = 1'b1;
                        uo.era    = 1'b1;
                    end
                    default: uo = UO_NONE;
                endcase
            end
            O0: begin
                // AC loads only on the cycle the memory completes
                case (co)
                    ST: begin
                        uo.sac = 1'b1;
                        uo.esc = 1'b1;
                    end
                    LD: begin
                        uo.lec    = 1'b1;
                        uo.eac    = mem_rdy;
                        uo.alu_op = ALU_PASS;
                    end
                    ADD: begin
                        uo.lec    = 1'b1;
                        uo.eac    = mem_rdy;
                        uo.alu_op = mem_rdy ? ALU_ADD : ALU_PASS;
                    end
                    default: uo = UO_NONE;
                endcase
            end
            O1: begin
                uo.scp = 1'b1;
                uo.era = 1'b1;
            end
            default: uo = UO_NONE;
        endcase
    end

endmodule

// File: rtl/simplez_ctrl.sv
// Simplez control unit: state register, END/run/step sequencing, reset gating.
// Optional single-step input enabled by defining SIMPLEZ_STEP_EN.
module simplez_ctrl
    import simplez_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
`ifdef SIMPLEZ_STEP_EN
    input  logic        step,
`endif
    input  logic [2:0]  co,
    input  logic        ac_zero,
    input  logic        mem_rdy,
    input  logic        run,
    output logic        lec,
    output logic        esc,
    output logic        era,
    output logic        eri,
    output logic        eac,
    output logic        sri,
    output logic        scp,
    output logic        sac,
    output logic        incp,
    output logic        ecp,
    output logic        ccp,
    output logic [1:0]  alu_op,
    output logic        stop,
    output logic        boundary,
    output logic [2:0]  state_dbg
);

    state_e   state_q;
    state_e   state_d;
    uorders_t uo;
    logic     last;
    logic     go;

    simplez_udecode u_udecode (
        .state   (state_q),
        .co      (co),
        .ac_zero (ac_zero),
        .mem_rdy (mem_rdy),
        .uo      (uo)
    );

`ifdef SIMPLEZ_STEP_EN
    // arm_q remembers step was low last cycle, so a held step fires once
    logic arm_q;
    logic arm_d;
    logic step_req;

    always_comb begin
        arm_d    = ~step;
        step_req = (state_q == IDLE) & step & arm_q;
        go       = run | step_req;
    end

    always_ff @(negedge clk) begin
        if (!rstn) arm_q <= 1'b0;
        else       arm_q <= arm_d;
    end
`else
    assign go = run;
`endif

    always_comb begin
        state_d = I0;
        last    = 1'b0;
        case (state_q)
            INI:  state_d = I0;
            I0:   state_d = mem_rdy ? I1 : I0;
            I1: begin
                case (co)
                    ST, LD, ADD: state_d = O0;
                    HALT:        state_d = HLT;
                    default:     last    = 1'b1;
                endcase
            end
            O0:   state_d = mem_rdy ? O1 : O0;
            O1:   last    = 1'b1;
            HLT:  state_d = HLT;
            IDLE: state_d = go ? I0 : IDLE;
            default: state_d = I0;
        endcase
        if (last) state_d = run ? I0 : IDLE;
    end

    always_ff @(negedge clk) begin
        if (!rstn) state_q <= INI;
        else       state_q <= state_d;
    end

    assign lec       = rstn & uo.lec;
    assign esc       = rstn & uo.esc;
    assign era       = rstn & uo.era;
    assign eri       = rstn & uo.eri;
    assign eac       = rstn & uo.eac;
    assign sri       = rstn & uo.sri;
    assign scp       = rstn & uo.scp;
    assign sac       = rstn & uo.sac;
    assign incp      = rstn & uo.incp;
    assign ecp       = rstn & uo.ecp;
    assign ccp       = rstn & uo.ccp;
    assign alu_op    = rstn ? uo.alu_op : 2'b00;
    assign stop      = rstn & (state_q == HLT);
    assign boundary  = rstn & last;
    assign state_dbg = rstn ? state_q : INI;

endmodule

// File: tb/tb_simplez_ctrl.sv
// Directed scoreboard bench for simplez_ctrl: per-cycle expected
// microorders/state are queued with the stimulus and checked each cycle.
module tb_simplez_ctrl;
    import simplez_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       ac_zero = 1'b0;
    logic       mem_rdy = 1'b1;
    logic       run = 1'b0;
    logic [2:0] co = ST;
`ifdef SIMPLEZ_STEP_EN
    logic       step = 1'b0;
`endif
    logic       lec, esc, era, eri, eac, sri, scp, sac;
    logic       incp, ecp, ccp, stop, boundary;
    logic [1:0] alu_op;
    logic [2:0] state_dbg;

    localparam logic [14:0] M_STOP = 15'h4000;
    localparam logic [14:0] M_BND  = 15'h2000;
    localparam logic [14:0] M_LEC  = 15'h1000;
    localparam logic [14:0] M_ESC  = 15'h0800;
    localparam logic [14:0] M_ERA  = 15'h0400;
    localparam logic [14:0] M_ERI  = 15'h0200;
    localparam logic [14:0] M_EAC  = 15'h0100;
    localparam logic [14:0] M_SRI  = 15'h0080;
    localparam logic [14:0] M_SCP  = 15'h0040;
    localparam logic [14:0] M_SAC  = 15'h0020;
    localparam logic [14:0] M_INCP = 15'h0010;
    localparam logic [14:0] M_ECP  = 15'h0008;
    localparam logic [14:0] M_CCP  = 15'h0004;
    localparam logic [14:0] A_ADD  = 15'h0001;
    localparam logic [14:0] A_DEC  = 15'h0002;
    localparam logic [14:0] A_ZERO = 15'h0003;
    localparam logic [14:0] FETCH  = M_LEC | M_ERI | M_INCP;

    typedef struct {
        string       tag;
        logic [17:0] vec;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    simplez_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
`ifdef SIMPLEZ_STEP_EN
        .step      (step),
`endif
        .co        (co),
        .ac_zero   (ac_zero),
        .mem_rdy   (mem_rdy),
        .run       (run),
        .lec       (lec),
        .esc       (esc),
        .era       (era),
        .eri       (eri),
        .eac       (eac),
        .sri       (sri),
        .scp       (scp),
        .sac       (sac),
        .incp      (incp),
        .ecp       (ecp),
        .ccp       (ccp),
        .alu_op    (alu_op),
        .stop      (stop),
        .boundary  (boundary),
        .state_dbg (state_dbg)
    );

    task automatic want(input string tag, input logic [2:0] st,
                        input logic [14:0] m);
        exp_t e;
        e.tag = tag;
        e.vec = {st, m};
        sbq.push_back(e);
    endtask

    // Outputs are checked mid-cycle, away from the falling active edge
    task automatic tick();
        exp_t        e;
        logic [17:0] obs;
        @(posedge clk);
        #1;
        obs = {state_dbg, stop, boundary, lec, esc, era, eri, eac,
               sri, scp, sac, incp, ecp, ccp, alu_op};
        e = sbq.pop_front();
        total++;
        assert (obs === e.vec) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h want %h", e.tag, obs, e.vec);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [2:0] st,
                       input logic [14:0] m);
        want(tag, st, m);
        tick();
    endtask

    initial begin
        cyc("reset", INI, 15'h0);
        rstn = 1'b1;
        run  = 1'b1;
        co   = LD;
        cyc("ld_ini", INI, M_CCP);
        cyc("ld_i0", I0, FETCH);
        cyc("ld_i1", I1, M_SRI | M_ERA);
        cyc("ld_o0", O0, M_LEC | M_EAC);
        cyc("ld_o1", O1, M_SCP | M_ERA | M_BND);

        co = BZ;
        ac_zero = 1'b1;
        cyc("bz1_i0", I0, FETCH);
        cyc("bz1_i1", I1, M_SRI | M_ECP | M_ERA | M_BND);
        ac_zero = 1'b0;
        cyc("bz0_i0", I0, FETCH);
        cyc("bz0_i1", I1, M_SCP | M_ERA | M_BND);

        co = ADD;
        mem_rdy = 1'b0;
        cyc("add_i0_wait", I0, M_LEC);
        mem_rdy = 1'b1;
        cyc("add_i0", I0, FETCH);
        cyc("add_i1", I1, M_SRI | M_ERA);
        mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) cyc("add_o0_wait", O0, M_LEC);
        mem_rdy = 1'b1;
        cyc("add_o0", O0, M_LEC | M_EAC | A_ADD);
        cyc("add_o1", O1, M_SCP | M_ERA | M_BND);

        co = ST;
        cyc("st_i0", I0, FETCH);
        cyc("st_i1", I1, M_SRI | M_ERA);
        run = 1'b0;
        cyc("st_o0", O0, M_SAC | M_ESC);
        cyc("st_o1", O1, M_SCP | M_ERA | M_BND);
        cyc("idle_a", IDLE, 15'h0);
        cyc("idle_b", IDLE, 15'h0);
        run = 1'b1;
        cyc("idle_go", IDLE, 15'h0);

        co = DEC;
        cyc("dec_i0", I0, FETCH);
        cyc("dec_i1", I1, M_EAC | A_DEC | M_SCP | M_ERA | M_BND);

        co = HALT;
        cyc("hlt_i0", I0, FETCH);
        cyc("hlt_i1", I1, 15'h0);
        cyc("hlt_a", HLT, M_STOP);
        run = 1'b0;
        cyc("hlt_run0", HLT, M_STOP);
        run = 1'b1;
        cyc("hlt_run1", HLT, M_STOP);
        rstn = 1'b0;
        cyc("hlt_rst", INI, 15'h0);
        rstn = 1'b1;
        cyc("ini_again", INI, M_CCP);

        co = LD;
        cyc("mid_i0", I0, FETCH);
        cyc("mid_i1", I1, M_SRI | M_ERA);
        rstn = 1'b0;
        cyc("mid_rst", INI, 15'h0);
        rstn = 1'b1;
        cyc("mid_ini", INI, M_CCP);

        co  = CLR;
        run = 1'b0;
        cyc("clr_i0", I0, FETCH);
        cyc("clr_i1", I1, M_EAC | A_ZERO | M_SCP | M_ERA | M_BND);
        cyc("clr_idle_a", IDLE, 15'h0);
        cyc("clr_idle_b", IDLE, 15'h0);

`ifdef SIMPLEZ_STEP_EN
        step = 1'b1;
        cyc("stp_idle", IDLE, 15'h0);
        cyc("stp_i0", I0, FETCH);
        cyc("stp_i1", I1, M_EAC | A_ZERO | M_SCP | M_ERA | M_BND);
        cyc("stp_hold_a", IDLE, 15'h0);
        cyc("stp_hold_b", IDLE, 15'h0);
        step = 1'b0;
        cyc("stp_low_a", IDLE, 15'h0);
        cyc("stp_low_b", IDLE, 15'h0);
`endif

        total++;
        assert (sbq.size() === 0) passed++;
        else begin
            failed++;
            $error("FAIL sb_drain: got %0d want 0", sbq.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
